// File: rtl/weight_ram_sched_pkg.sv
// Shared DQN weight-RAM definitions: layer codes, RAM address width and per-layer depth.
// Pure declarations; no timing or backpressure of its own.
package weight_ram_sched_pkg;

    localparam int ADDR_WIDTH = 11;

    localparam logic [1:0] LAYER_NONE = 2'b00;
    localparam logic [1:0] LAYER_HID1 = 2'b01;
    localparam logic [1:0] LAYER_HID2 = 2'b10;
    localparam logic [1:0] LAYER_OUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DONE  = 2'b10
    } sched_state_e;

    // Each neuron stores one weight per input plus a bias word.
    function automatic logic [ADDR_WIDTH-1:0] layer_depth(
        input logic [1:0] layer,
        input int         n_in,
        input int         n_h1,
        input int         n_h2,
        input int         n_out
    );
        int d;
        case (layer)
            LAYER_HID1: d = n_h1 * (n_in + 1);
            LAYER_HID2: d = n_h2 * (n_h1 + 1);
            LAYER_OUT:  d = n_out * (n_h2 + 1);
            default:    d = 0;
        endcase
        return d[ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/weight_ram_sched_counter.sv
// Read address counter: synchronous clear, increment-enable, wraps after depth-1.
// Terminal flag is combinational from the count; the caller stalls by withholding inc_i.
module weight_addr_counter
    import weight_ram_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  inc_i,
    input  logic [ADDR_WIDTH-1:0] depth_i,
    output logic [ADDR_WIDTH-1:0] cnt_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;

    assign last_o = (cnt_q == depth_i - ADDR_WIDTH'(1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/weight_ram_sched.sv
// Weight RAM scheduler: layer read bursts interleaved with writes, commands registered (1-cycle latency).
// Writes stall via o_wr_ready, which during a burst alternates with reads so neither side starves.
module weight_ram_sched
    import weight_ram_sched_pkg::*;
#(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int NUMBER_OF_INPUT_NODE          = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rd_start,
    input  logic [LAYER_WIDTH-1:0] i_rd_layer,
    output logic                   o_rd_busy,
    output logic                   o_rd_done,
    input  logic                   i_wr_valid,
    input  logic [LAYER_WIDTH-1:0] i_wr_layer,
    input  logic [ADDR_WIDTH-1:0]  i_wr_addr,
    input  logic [DATA_WIDTH-1:0]  i_wr_data,
    output logic                   o_wr_ready,
    output logic                   o_ram_enable,
    output logic                   o_rw_select,
    output logic [LAYER_WIDTH-1:0] o_weight_layer,
    output logic [ADDR_WIDTH-1:0]  o_weight_addr,
    output logic [DATA_WIDTH-1:0]  o_weight
);

    sched_state_e           state_q, state_d;
    logic [LAYER_WIDTH-1:0] burst_layer_q, burst_layer_d;
    logic                   last_rd_q, last_rd_d;
    logic                   ram_en_q, ram_en_d;
    logic                   rw_sel_q, rw_sel_d;
    logic [LAYER_WIDTH-1:0] wlayer_q, wlayer_d;
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]  weight_q, weight_d;

    logic                   cnt_clr, cnt_inc, cnt_last;
    logic [ADDR_WIDTH-1:0]  cnt, depth;
    logic                   wr_fire;

    assign depth = layer_depth(2'(burst_layer_q), NUMBER_OF_INPUT_NODE,
                               NUMBER_OF_HIDDEN_NODE_LAYER_1,
                               NUMBER_OF_HIDDEN_NODE_LAYER_2,
                               NUMBER_OF_OUTPUT_NODE);

    weight_addr_counter u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .depth_i (depth),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    assign o_wr_ready = (state_q != ST_BURST) || last_rd_q;
    assign wr_fire    = i_wr_valid && o_wr_ready;

    always_comb begin
        state_d       = state_q;
        burst_layer_d = burst_layer_q;
        last_rd_d     = last_rd_q;
        ram_en_d      = 1'b0;
        rw_sel_d      = rw_sel_q;
        wlayer_d      = wlayer_q;
        waddr_d       = waddr_q;
        weight_d      = weight_q;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;

        // A granted write owns this cycle's command slot, including the start cycle.
        if (wr_fire) begin
            ram_en_d  = 1'b1;
            rw_sel_d  = 1'b0;
            wlayer_d  = i_wr_layer;
            waddr_d   = i_wr_addr;
            weight_d  = i_wr_data;
            last_rd_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_rd_start && (|i_rd_layer)) begin
                    state_d       = ST_BURST;
                    burst_layer_d = i_rd_layer;
                    cnt_clr       = 1'b1;
                end
            end
            ST_BURST: begin
                if (!wr_fire) begin
                    ram_en_d  = 1'b1;
                    rw_sel_d  = 1'b1;
                    wlayer_d  = burst_layer_q;
                    waddr_d   = cnt;
                    weight_d  = '0;
                    last_rd_d = 1'b1;
                    cnt_inc   = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            burst_layer_q <= '0;
            last_rd_q     <= 1'b0;
            ram_en_q      <= 1'b0;
            rw_sel_q      <= 1'b0;
            wlayer_q      <= '0;
            waddr_q       <= '0;
            weight_q      <= '0;
        end else begin
            state_q       <= state_d;
            burst_layer_q <= burst_layer_d;
            last_rd_q     <= last_rd_d;
            ram_en_q      <= ram_en_d;
            rw_sel_q      <= rw_sel_d;
            wlayer_q      <= wlayer_d;
            waddr_q       <= waddr_d;
            weight_q      <= weight_d;
        end
    end

    assign o_rd_busy      = (state_q == ST_BURST);
    assign o_rd_done      = (state_q == ST_DONE);
    assign o_ram_enable   = ram_en_q;
    assign o_rw_select    = rw_sel_q;
    assign o_weight_layer = wlayer_q;
    assign o_weight_addr  = waddr_q;
    assign o_weight       = weight_q;

endmodule
